// File: rtl/coin_credit_controller_pkg.sv
// Shared types and helpers for the coin credit controller: FSM states,
// default denominations and saturating arithmetic.
package coin_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  localparam int unsigned COIN_100 = 100;
  localparam int unsigned COIN_500 = 500;

  // Wide enough that no sum of a credit and a cycle's coins can wrap.
  localparam int unsigned SUM_W = 64;

  function automatic logic [SUM_W-1:0] sat_max(input int unsigned width);
    return (SUM_W'(1) << width) - SUM_W'(1);
  endfunction

  function automatic logic add_saturates(input logic [SUM_W-1:0] a,
                                         input logic [SUM_W-1:0] b,
                                         input int unsigned      width);
    return (a + b) > sat_max(width);
  endfunction

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                               input logic [SUM_W-1:0] b,
                                               input int unsigned      width);
    return add_saturates(a, b, width) ? sat_max(width) : (a + b);
  endfunction

endpackage

// File: rtl/coin_edge_detect.sv
// Per-channel rising-edge detector for the coin sensor levels.
module coin_edge_detect #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev <= '0;
    else        prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/coin_credit_controller.sv
// Coin acceptor / vending controller: credits coin edges, compares against
// price, pulses vend and hands change out over a valid/ready handshake.
module coin_credit_controller
  import coin_pkg::*;
#(
  parameter int unsigned NUM_COIN_TYPES = 2,
  parameter int unsigned CREDIT_W       = 16,
  parameter int unsigned COUNT_W        = 8,
  parameter logic [NUM_COIN_TYPES-1:0][31:0] COIN_VALUES = {32'(COIN_500), 32'(COIN_100)}
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_COIN_TYPES-1:0] coin_in,
  input  logic [CREDIT_W-1:0]       price,
  input  logic                      vend_req,
  input  logic                      cancel,
  input  logic                      change_ready,
  output logic [CREDIT_W-1:0]       credit,
  output logic                      vend,
  output logic                      change_valid,
  output logic [CREDIT_W-1:0]       change_amt,
  output logic                      coin_reject,
  output logic [COUNT_W-1:0]        total_coins,
  output logic                      overflow
);

  state_t                    state;
  logic [NUM_COIN_TYPES-1:0] rise;
  logic [SUM_W-1:0]          coin_sum;
  logic [SUM_W-1:0]          coin_cnt;
  logic [CREDIT_W-1:0]       credit_upd;
  logic [COUNT_W-1:0]        count_upd;
  logic                      credit_sat;
  logic                      coin_seen;
  logic [CREDIT_W-1:0]       price_q;

  coin_edge_detect #(
    .WIDTH (NUM_COIN_TYPES)
  ) u_edge (
    .clk   (clk),
    .reset (reset),
    .level (coin_in),
    .rise  (rise)
  );

  always_comb begin
    coin_sum = '0;
    coin_cnt = '0;
    for (int unsigned i = 0; i < NUM_COIN_TYPES; i++) begin
      if (rise[i]) begin
        coin_sum = coin_sum + SUM_W'(COIN_VALUES[i]);
        coin_cnt = coin_cnt + SUM_W'(1);
      end
    end
    credit_upd = CREDIT_W'(sat_add(SUM_W'(credit), coin_sum, CREDIT_W));
    credit_sat = add_saturates(SUM_W'(credit), coin_sum, CREDIT_W);
    count_upd  = COUNT_W'(sat_add(SUM_W'(total_coins), coin_cnt, COUNT_W));
  end

  assign coin_seen = |rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      credit       <= '0;
      vend         <= 1'b0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      coin_reject  <= 1'b0;
      total_coins  <= '0;
      overflow     <= 1'b0;
      price_q      <= '0;
    end else begin
      vend        <= 1'b0;
      coin_reject <= 1'b0;
      unique case (state)
        IDLE: begin
          if (coin_seen) begin
            credit      <= credit_upd;
            total_coins <= count_upd;
            overflow    <= overflow | credit_sat;
            state       <= ACCUM;
          end
        end
        ACCUM: begin
          // Coins of this cycle are credited before cancel / price compare.
          total_coins <= count_upd;
          overflow    <= overflow | credit_sat;
          if (cancel) begin
            change_amt   <= credit_upd;
            credit       <= '0;
            change_valid <= 1'b1;
            state        <= CHANGE;
          end else if (vend_req && (credit_upd >= price)) begin
            credit  <= credit_upd;
            price_q <= price;
            state   <= VEND;
          end else begin
            credit <= credit_upd;
          end
        end
        VEND: begin
          vend        <= 1'b1;
          coin_reject <= coin_seen;
          change_amt  <= credit - price_q;
          credit      <= '0;
          state       <= (credit != price_q) ? CHANGE : IDLE;
        end
        CHANGE: begin
          // Entered from VEND with valid low so it rises one cycle after vend.
          coin_reject <= coin_seen;
          if (change_valid && change_ready) begin
            change_valid <= 1'b0;
            change_amt   <= '0;
            state        <= IDLE;
          end else begin
            change_valid <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
